// File: rtl/led_sr_tx.sv
// Serial transmitter for a 74HC595-style LED chain: shifts a WIDTH-bit pattern out on sdo/sclk, then pulses rclk.
// Build option: define LED_SR_LSB_FIRST_EN to send LSB first (MSB first otherwise).
module led_sr_tx #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clki,
   input  logic             rs,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   output logic             sdo,
   output logic             sclk,
   output logic             rclk,
   output logic             busy,
   output logic             done
);

   localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BCW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, LATCH = 2'd3} state_t;

   state_t           state, state_d;
   logic [DCW-1:0]   dc, dc_d;
   logic [BCW-1:0]   bc, bc_d;
   logic [WIDTH-1:0] sr, sr_d;
   logic             sdo_d, sclk_d, rclk_d, busy_d, done_d;
   logic             dc_end, bc_last;

   assign dc_end  = (dc == DCW'(DIV - 1));
   assign bc_last = (bc == BCW'(WIDTH - 1));

   always_ff @(posedge clki) begin
      if (!rs) begin
         state <= IDLE;
         dc    <= '0;
         bc    <= '0;
         sr    <= '0;
         sdo   <= 1'b0;
         sclk  <= 1'b0;
         rclk  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         dc    <= dc_d;
         bc    <= bc_d;
         sr    <= sr_d;
         sdo   <= sdo_d;
         sclk  <= sclk_d;
         rclk  <= rclk_d;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start)  state_d = LOW;
         LOW:     if (dc_end) state_d = HIGH;
         HIGH:    if (dc_end) state_d = bc_last ? LATCH : LOW;
         LATCH:   if (dc_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pin levels are registered copies of the next state, so the board never sees decode glitches.
   always_comb begin
      dc_d  = (state == IDLE || dc_end) ? '0 : dc + DCW'(1);
      bc_d  = bc;
      sr_d  = sr;
      sdo_d = sdo;
      case (state)
         IDLE: begin
            sdo_d = 1'b0;
            if (start) begin
               sr_d = data;
               bc_d = '0;
`ifdef LED_SR_LSB_FIRST_EN
               sdo_d = data[0];
`else
               sdo_d = data[WIDTH-1];
`endif
            end
         end
         HIGH: begin
            if (dc_end) begin
               if (bc_last) begin
                  sdo_d = 1'b0;
               end else begin
                  bc_d = bc + BCW'(1);
`ifdef LED_SR_LSB_FIRST_EN
                  sr_d  = sr >> 1;
                  sdo_d = sr[1];
`else
                  sr_d  = sr << 1;
                  sdo_d = sr[WIDTH-2];
`endif
               end
            end
         end
         LATCH:   sdo_d = 1'b0;
         default: ;
      endcase
      sclk_d = (state_d == HIGH);
      rclk_d = (state_d == LATCH);
      busy_d = (state_d != IDLE);
      done_d = (state == LATCH) && dc_end;
   end

endmodule

// File: tb/tb_led_sr_tx.sv
// Bench for led_sr_tx: directed and random stimulus checked against a per-cycle expected pin trace.
module tb_led_sr_tx;
   localparam int W = 8;
   localparam int D = 2;

   logic         clki = 1'b0;
   logic         rs = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] data = '0;
   logic         sdo, sclk, rclk, busy, done;

   led_sr_tx #(.WIDTH(W), .DIV(D)) dut (
      .clki(clki), .rs(rs), .start(start), .data(data),
      .sdo(sdo), .sclk(sclk), .rclk(rclk), .busy(busy), .done(done)
   );

   always #5 clki = ~clki;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Expected pins after each edge, packed {sdo,sclk,rclk,busy,done}.
   logic [4:0]   q[$];
   logic [4:0]   cur = '0;
   logic [W-1:0] last_data = '0;
   logic [W-1:0] rx = '0;
   int           rx_cnt = 0;
   int           rises = 0;
   logic         psclk = 1'b0, prclk = 1'b0;

   function automatic logic bit_at(input logic [W-1:0] d, input int i);
`ifdef LED_SR_LSB_FIRST_EN
      return d[i];
`else
      return d[W-1-i];
`endif
   endfunction

   task automatic push_frame(input logic [W-1:0] d);
      for (int i = 0; i < W; i++) begin
         for (int k = 0; k < D; k++) q.push_back({bit_at(d, i), 4'b0010});
         for (int k = 0; k < D; k++) q.push_back({bit_at(d, i), 4'b1010});
      end
      for (int k = 0; k < D; k++) q.push_back(5'b00110);
      q.push_back(5'b00001);
   endtask

   task automatic step();
      @(posedge clki);
      if (!rs) begin
         q.delete();
         cur = '0;
      end else begin
         if (!cur[1] && start) begin
            push_frame(data);
            last_data = data;
            rx_cnt = 0;
         end
         cur = (q.size() > 0) ? q.pop_front() : 5'b0;
      end
      #1;
      chk("pins", {sdo, sclk, rclk, busy, done}, cur);
      if (sclk && !psclk) begin
         rises++;
         rx_cnt++;
`ifdef LED_SR_LSB_FIRST_EN
         rx = {sdo, rx[W-1:1]};
`else
         rx = {rx[W-2:0], sdo};
`endif
      end
      if (rclk && !prclk) begin
         chk("nbits", rx_cnt, W);
         chk("frame", rx, last_data);
      end
      psclk = sclk;
      prclk = rclk;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int r0;
      // reset held with start asserted
      rs = 1'b0; start = 1'b1; data = 8'hA5;
      run(3);
      // single frame A5
      rs = 1'b1;
      step();
      start = 1'b0;
      run(40);
      // start ignored while busy
      data = 8'h3C; start = 1'b1;
      step();
      data = 8'hFF;
      run(20);
      start = 1'b0;
      run(20);
      // back-to-back with start held
      data = 8'h01; start = 1'b1;
      run(5);
      data = 8'h80;
      run(32);
      start = 1'b0;
      run(40);
      // mid-frame reset after the third sclk rise
      data = 8'hC3; start = 1'b1;
      step();
      start = 1'b0;
      r0 = rises;
      for (int i = 0; i < 100 && rises < r0 + 3; i++) step();
      chk("rise_wait", rises - r0, 3);
      rs = 1'b0;
      step();
      chk("rst_pins", {sdo, sclk, rclk, busy, done}, 0);
      rs = 1'b1;
      run(40);
      // random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 9) == 0);
         data  = W'($urandom);
         rs    = ($urandom_range(0, 199) != 0);
         step();
      end
      rs = 1'b1; start = 1'b0;
      run(50);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
